fir_mc: RTL

Multi-channel, runtime-reprogrammable FIR filter for the audio path. It is the parametrised successor to the single-channel time-multiplexed FIR and uses one multiply-accumulate per clock. It keeps an independent delay line per channel and shares one coefficient bank that can be rewritten at run time. It adds a ready/valid input handshake, a channel tag on input and output, and saturating output scaling.

---
 rtl/fir_mc_pkg.sv | 51 +++++
 rtl/fir_coef_bank.sv | 30 +++
 rtl/fir_mc.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_mc_pkg.sv
// rtl/fir_mc_pkg.sv - shared types, default coefficients and arithmetic helpers for fir_mc
package fir_mc_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  localparam int DEF_TAPS = 30;

  // Symmetric 30-tap lowpass loaded into the coefficient bank on reset
  localparam logic signed [15:0] DEF_COEF [DEF_TAPS] = '{
    16'sd292,   16'sd303,   16'sd310,   16'sd167,   -16'sd140,
    -16'sd555,  -16'sd947,  -16'sd1133, -16'sd936,  -16'sd244,
    16'sd930,   16'sd2435,  16'sd3997,  16'sd5288,  16'sd6019,
    16'sd6019,  16'sd5288,  16'sd3997,  16'sd2435,  16'sd930,
    -16'sd244,  -16'sd936,  -16'sd1133, -16'sd947,  -16'sd555,
    -16'sd140,  16'sd167,   16'sd310,   16'sd303,   16'sd292
  };

  // Accumulator width that cannot overflow for a full sum of products
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Default coefficient for tap k, sign-extended; taps beyond the table read as zero
  function automatic logic signed [31:0] default_coef(input int k);
    logic signed [31:0] r;
    r = '0;
    if (k >= 0 && k < DEF_TAPS) r = 32'(DEF_COEF[k[4:0]]);
    return r;
  endfunction

  // Clamp s into a signed data_w-bit range, flagging when clamping occurred
  function automatic logic signed [63:0] saturate(input logic signed [63:0] s, input int data_w,
                                                  output logic sat);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] r;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    sat = 1'b0;
    r = s;
    if (s > max_v) begin
      r = max_v;
      sat = 1'b1;
    end else if (s < min_v) begin
      r = min_v;
      sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shared coefficient register file, one write port, one async read port
module fir_coef_bank #(
  parameter int TAPS   = 30,
  parameter int COEF_W = 16,
  parameter int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic signed [COEF_W-1:0] wr_data_i,
  input  logic [AW-1:0]            rd_addr_i,
  output logic signed [COEF_W-1:0] rd_data_o
);
  import fir_mc_pkg::*;

  logic signed [COEF_W-1:0] coef_q [TAPS];

  // Reload the lowpass defaults on reset, otherwise take gated writes to valid taps
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= COEF_W'(default_coef(i));
    end else if (wr_en_i && (32'(wr_addr_i) < TAPS)) begin
      coef_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = coef_q[rd_addr_i];

endmodule

// File: rtl/fir_mc.sv
// rtl/fir_mc.sv - multi-channel single-MAC FIR with shared reprogrammable coefficients
module fir_mc #(
  parameter int TAPS     = 30,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW      = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               right_shift,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_channel,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     coef_wr_en,
  input  logic [AW-1:0]            coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_channel,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     out_sat
);
  import fir_mc_pkg::*;

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  state_e                     state_q, state_d;
  logic [AW-1:0]              k_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d, s_shift;
  logic [CH_W-1:0]            ch_q;
  logic [5:0]                 shift_q;
  logic signed [DATA_W-1:0]   dline_q [CHANNELS][TAPS];
  logic signed [COEF_W-1:0]   coef_rd;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic                       mac_en, out_en, accept, start;
  logic                       out_valid_q, out_sat_q, sat_d;
  logic [CH_W-1:0]            out_channel_q;
  logic signed [DATA_W-1:0]   data_out_q, data_d;

  // Out-of-range channels complete the handshake but never start a computation
  assign accept = in_valid && in_ready;
  assign start  = accept && (32'(in_channel) < CHANNELS);

  fir_coef_bank #(.TAPS(TAPS), .COEF_W(COEF_W), .AW(AW)) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (coef_wr_en && in_ready),
    .wr_addr_i (coef_wr_addr),
    .wr_data_i (coef_wr_data),
    .rd_addr_i (k_q),
    .rd_data_o (coef_rd)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one MAC pass of TAPS cycles, then a single OUT cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (k_q == AW'(TAPS - 1)) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only while idle and out of reset
  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
    mac_en   = (state_q == MAC);
    out_en   = (state_q == OUT);
  end

  // Per-channel delay lines; only the accepted channel shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++) dline_q[c][t] <= '0;
    end else if (start) begin
      for (int t = TAPS - 1; t > 0; t--) dline_q[in_channel][t] <= dline_q[in_channel][t-1];
      dline_q[in_channel][0] <= data_in;
    end
  end

  // Product of the current tap, sign-extended into the accumulator
  always_comb begin
    prod  = dline_q[ch_q][k_q] * coef_rd;
    acc_d = acc_q + ACC_W'(prod);
  end

  // Transaction context latched on accept, accumulation during MAC
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      acc_q   <= '0;
      ch_q    <= '0;
      shift_q <= '0;
    end else if (start) begin
      k_q     <= '0;
      acc_q   <= '0;
      ch_q    <= in_channel;
      shift_q <= right_shift;
    end else if (mac_en) begin
      k_q   <= k_q + AW'(1);
      acc_q <= acc_d;
    end
  end

  // Scale by the latched shift (saturating to the sign once it exceeds the width), then clamp
  always_comb begin
    s_shift = acc_q >>> shift_q;
    if (32'(shift_q) >= ACC_W) s_shift = {ACC_W{acc_q[ACC_W-1]}};
    sat_d  = 1'b0;
    data_d = DATA_W'(saturate(64'(s_shift), DATA_W, sat_d));
  end

  // Result registers hold between OUT cycles; the strobe lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      data_out_q    <= '0;
      out_sat_q     <= 1'b0;
    end else begin
      out_valid_q <= out_en;
      if (out_en) begin
        out_channel_q <= ch_q;
        data_out_q    <= data_d;
        out_sat_q     <= sat_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign data_out    = data_out_q;
  assign out_sat     = out_sat_q;

endmodule
